// File: rtl/uart_tx_sched.sv
// Two-port round-robin byte scheduler in front of uart_tx; `UART_TX_SCHED_STAT_EN adds the sent_cnt counter.
// Latency: push into an empty FIFO while idle -> pop on the next edge, tx_start high in the cycle after it.
// Backpressure: pN_ready = !full with no credit for a same-cycle pop; uart_tx paced by tx_start/tx_busy.

module uart_tx_sched_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push_i,
    input  logic [7:0]            wdata_i,
    input  logic                  pop_i,
    output logic [7:0]            rdata_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]   level_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PTR_ONE;
            if (pop_i)  rptr_q <= rptr_q + PTR_ONE;
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LVL_FULL);
    assign empty_o = (level_q == '0);
endmodule

module uart_tx_sched #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [7:0]            p0_data,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic [7:0]            p1_data,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    output logic [DEPTH_LOG2:0]   p0_level,
    output logic [DEPTH_LOG2:0]   p1_level,
    output logic [7:0]            tx_sdata,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  sched_idle,
    output logic [31:0]           sent_cnt
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] sdata_q, sdata_d;
    logic       pop0, pop1, grant1;
    logic       full0, full1, empty0, empty1;
    logic [7:0] rdata0, rdata1;

    uart_tx_sched_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo0 (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (p0_valid && !full0),
        .wdata_i (p0_data),
        .pop_i   (pop0),
        .rdata_o (rdata0),
        .level_o (p0_level),
        .full_o  (full0),
        .empty_o (empty0)
    );

    uart_tx_sched_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo1 (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (p1_valid && !full1),
        .wdata_i (p1_data),
        .pop_i   (pop1),
        .rdata_o (rdata1),
        .level_o (p1_level),
        .full_o  (full1),
        .empty_o (empty1)
    );

    // Port 1 wins when it is the only one pending, or on a tie when port 0 went last.
    assign grant1 = !empty1 && (empty0 || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sdata_d      = sdata_q;
        pop0         = 1'b0;
        pop1         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty0 || !empty1) begin
                    pop0         = !grant1;
                    pop1         = grant1;
                    sdata_d      = grant1 ? rdata1 : rdata0;
                    last_grant_d = grant1;
                    state_d      = S_START;
                end
            end
            S_START:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy)  state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            sdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sdata_q      <= sdata_d;
        end
    end

    assign tx_start   = (state_q == S_START);
    assign tx_sdata   = sdata_q;
    assign p0_ready   = !full0;
    assign p1_ready   = !full1;
    assign sched_idle = (state_q == S_IDLE) && empty0 && empty1;

`ifdef UART_TX_SCHED_STAT_EN
    logic [31:0] sent_q;

    always_ff @(posedge clk) begin
        if (!rstn)                    sent_q <= '0;
        else if (state_q == S_START)  sent_q <= sent_q + 32'd1;
    end

    assign sent_cnt = sent_q;
`else
    assign sent_cnt = '0;
`endif
endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  p0_data = '0, p1_data = '0;
    logic        p0_valid = 1'b0, p1_valid = 1'b0;
    logic        p0_ready, p1_ready;
    logic [4:0]  p0_level, p1_level;
    logic [7:0]  tx_sdata;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        sched_idle;
    logic [31:0] sent_cnt;

    uart_tx_sched #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rstn(rstn),
        .p0_data(p0_data), .p0_valid(p0_valid), .p0_ready(p0_ready),
        .p1_data(p1_data), .p1_valid(p1_valid), .p1_ready(p1_ready),
        .p0_level(p0_level), .p1_level(p1_level),
        .tx_sdata(tx_sdata), .tx_start(tx_start), .tx_busy(tx_busy),
        .sched_idle(sched_idle), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] b; int c; } exp_t;
    exp_t       exp_q[$];
    logic [7:0] q0[$], q1[$], log_q[$];
    int cyc = 0, next_free = 0, last_m = 1, sent_m = 0;
    int fidx_m = 0, fidx_u = 0, fixed_len = 0, rem = 0;
    int lens[256];
    int n_chk = 0, n_err = 0, starts = 0, max_lvl0 = 0;
    bit chk_en = 0, start_seen = 0;
    logic [7:0] cur_byte = '0;
    logic [7:0] rr_exp[5] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12};

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic int flen(input int idx);
        return (fixed_len > 0) ? fixed_len : lens[idx & 255];
    endfunction

    // Reference: per-port byte queues capped at 16; a grant is possible once the previous
    // frame has ended (start + frame length + 3 cycles of handshake), round-robin on ties.
    always @(posedge clk) begin : model
        bit a0, a1;
        int port;
        logic [7:0] b;
        cyc++;
        if (!rstn) begin
            q0.delete(); q1.delete(); exp_q.delete();
            last_m = 1; next_free = 0; sent_m = 0;
        end else begin
            a0 = p0_valid && (q0.size() < 16);
            a1 = p1_valid && (q1.size() < 16);
            if (cyc >= next_free && (q0.size() > 0 || q1.size() > 0)) begin
                if (q0.size() > 0 && q1.size() > 0) port = (last_m == 0) ? 1 : 0;
                else                                port = (q0.size() > 0) ? 0 : 1;
                b = (port == 1) ? q1.pop_front() : q0.pop_front();
                last_m = port;
                exp_q.push_back('{b: b, c: cyc});
                next_free = cyc + flen(fidx_m) + 3;
                fidx_m++;
                sent_m++;
            end
            if (a0) q0.push_back(p0_data);
            if (a1) q1.push_back(p1_data);
        end
    end

    // uart_tx stand-in: busy rises one edge after the start pulse, falls a frame length later.
    always @(posedge clk) begin : uart
        bit r, s;
        r = rstn;
        s = start_seen;
        #1;
        if (!r) begin
            tx_busy = 1'b0; rem = 0;
        end else if (s) begin
            tx_busy = 1'b1; rem = flen(fidx_u); fidx_u++;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) tx_busy = 1'b0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        start_seen = tx_start;
        if (chk_en) begin
            chk(p0_level == q0.size(), "p0_level", p0_level, q0.size());
            chk(p1_level == q1.size(), "p1_level", p1_level, q1.size());
            chk(p0_ready == (q0.size() < 16), "p0_ready", p0_ready, q0.size() < 16);
            chk(p1_ready == (q1.size() < 16), "p1_ready", p1_ready, q1.size() < 16);
            if (int'(p0_level) > max_lvl0) max_lvl0 = int'(p0_level);
            if (tx_start) begin
                starts++;
                log_q.push_back(tx_sdata);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_start", tx_sdata, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(tx_sdata == e.b, "tx_sdata", tx_sdata, e.b);
                    chk(cyc == e.c, "start_cycle", cyc, e.c);
                    cur_byte = e.b;
                end
            end
            if (tx_busy) chk(tx_sdata == cur_byte, "sdata_hold", tx_sdata, cur_byte);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && cyc >= next_free)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(n < budget, name, n, budget);
        @(negedge clk);
        chk(sched_idle == 1'b1, "sched_idle", sched_idle, 1);
`ifdef UART_TX_SCHED_STAT_EN
        chk(sent_cnt == 32'(sent_m), "sent_cnt", sent_cnt, sent_m);
`else
        chk(sent_cnt == 32'd0, "sent_cnt", sent_cnt, 0);
`endif
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int s0, d, n;
        bit acc;
        for (int i = 0; i < 256; i++) lens[i] = $urandom_range(1, 6);

        // Reset with p0_valid held high: nothing may be pushed.
        rstn = 1'b0; p0_valid = 1'b1; p0_data = 8'h55;
        tick(); tick();
        chk_en = 1'b1;
        rstn = 1'b1; p0_valid = 1'b0;
        @(negedge clk);
        chk(tx_start == 1'b0, "rst_tx_start", tx_start, 0);
        chk(p0_level == 5'd0, "rst_p0_level", p0_level, 0);
        chk(p0_ready == 1'b1, "rst_p0_ready", p0_ready, 1);
        chk(sched_idle == 1'b1, "rst_sched_idle", sched_idle, 1);
        chk(sent_cnt == 32'd0, "rst_sent_cnt", sent_cnt, 0);

        // Single byte with a long frame.
        tick();
        fixed_len = 1000; log_q.delete(); s0 = starts;
        p0_data = 8'h41; p0_valid = 1'b1;
        tick();
        p0_valid = 1'b0;
        wait_drain(3000, "single_drain");
        chk(starts - s0 == 1, "single_start_count", starts - s0, 1);
        chk(log_q.size() == 1 && log_q[0] == 8'h41, "single_byte", log_q.size() > 0 ? log_q[0] : 0, 8'h41);

        // Round-robin preload.
        tick();
        do_reset();
        fixed_len = 4; log_q.delete();
        p0_valid = 1'b1; p0_data = 8'h10; p1_valid = 1'b1; p1_data = 8'h20; tick();
        p0_data = 8'h11; p1_data = 8'h21; tick();
        p0_data = 8'h12; p1_valid = 1'b0; tick();
        p0_valid = 1'b0;
        wait_drain(500, "rr_drain");
        chk(log_q.size() == 5, "rr_count", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++)
            chk(log_q[i] == rr_exp[i], "rr_order", log_q[i], rr_exp[i]);
`ifdef UART_TX_SCHED_STAT_EN
        chk(sent_cnt == 32'd5, "rr_sent_cnt", sent_cnt, 5);
`else
        chk(sent_cnt == 32'd0, "rr_sent_cnt", sent_cnt, 0);
`endif

        // Full boundary on p1 while the FSM waits on a long frame.
        tick();
        fixed_len = 60; log_q.delete();
        p0_data = 8'hAA; p0_valid = 1'b1; tick();
        p0_valid = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 17; i++) begin
            p1_valid = 1'b1;
            p1_data = (i < 16) ? 8'(i) : 8'hFF;
            tick();
        end
        p1_valid = 1'b0;
        fixed_len = 2;
        @(negedge clk);
        chk(p1_level == 5'd16, "full_level", p1_level, 16);
        chk(p1_ready == 1'b0, "full_ready", p1_ready, 0);
        chk(tx_busy == 1'b1, "full_still_busy", tx_busy, 1);
        wait_drain(3000, "full_drain");
        chk(log_q.size() == 17, "full_count", log_q.size(), 17);
        for (int i = 1; i < 17 && i < log_q.size(); i++)
            chk(log_q[i] == 8'(i - 1), "full_order", log_q[i], i - 1);

        // Pointer wrap: 40 bytes streamed with valid held high.
        tick();
        fixed_len = 2; log_q.delete(); max_lvl0 = 0; d = 0; n = 0;
        p0_valid = 1'b1;
        while (d < 40 && n < 2000) begin
            p0_data = 8'(d);
            @(negedge clk); acc = p0_ready;
            tick();
            if (acc) d++;
            n++;
        end
        p0_valid = 1'b0;
        chk(d == 40, "wrap_pushed", d, 40);
        wait_drain(1000, "wrap_drain");
        chk(log_q.size() == 40, "wrap_count", log_q.size(), 40);
        for (int i = 0; i < 40 && i < log_q.size(); i++)
            chk(log_q[i] == 8'(i), "wrap_order", log_q[i], i);
        chk(max_lvl0 <= 16, "wrap_max_level", max_lvl0, 16);

        // Random traffic on both ports with random frame lengths.
        tick();
        fixed_len = 0;
        for (int i = 0; i < 400; i++) begin
            p0_valid = 1'($urandom_range(0, 1)); p0_data = 8'($urandom);
            p1_valid = 1'($urandom_range(0, 1)); p1_data = 8'($urandom);
            tick();
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        wait_drain(3000, "rand_drain");

        // Reset mid-frame with three bytes still queued.
        tick();
        fixed_len = 50;
        for (int i = 0; i < 4; i++) begin
            p0_valid = 1'b1; p0_data = 8'hA0 + 8'(i); tick();
        end
        p0_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk(p0_level == 5'd3, "mid_queued", p0_level, 3);
        tick();
        do_reset();
        @(negedge clk);
        chk(p0_level == 5'd0, "mid_p0_level", p0_level, 0);
        chk(p1_level == 5'd0, "mid_p1_level", p1_level, 0);
        chk(sched_idle == 1'b1, "mid_idle", sched_idle, 1);
        s0 = starts;
        repeat (20) tick();
        chk(starts == s0, "mid_no_start", starts - s0, 0);
        fixed_len = 3; log_q.delete();
        p1_valid = 1'b1; p1_data = 8'h5A; tick();
        p1_valid = 1'b0;
        wait_drain(200, "mid_after_drain");
        chk(log_q.size() == 1 && log_q[0] == 8'h5A, "mid_after_byte", log_q.size() > 0 ? log_q[0] : 0, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Two-requester transmit scheduler in front of the single `uart_tx` serializer.
- Requester 0 is the core's output-instruction port; requester 1 is the loader/debug echo path.
- Each requester has its own byte FIFO. The scheduler arbitrates round-robin between non-empty FIFOs and sequences `uart_tx` through its `tx_start` / `tx_busy` handshake, one byte at a time.
- Neither requester ever sees `uart_tx` timing directly.

Parameters:
- `DEPTH_LOG2`, default 4: each per-port FIFO holds 2**DEPTH_LOG2 bytes (16).

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  reset, synchronous, active-low
- `p0_data`  in  8  port-0 byte
- `p0_valid`  in  1  port-0 byte offered
- `p0_ready`  out  1  port-0 FIFO can accept
- `p1_data`  in  8  port-1 byte
- `p1_valid`  in  1  port-1 byte offered
- `p1_ready`  out  1  port-1 FIFO can accept
- `p0_level`  out  DEPTH_LOG2+1  port-0 FIFO occupancy
- `p1_level`  out  DEPTH_LOG2+1  port-1 FIFO occupancy
- `tx_sdata`  out  8  byte to `uart_tx`
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`
- `tx_busy`  in  1  `uart_tx` busy flag; registered, rises the cycle after `tx_start`
- `sched_idle`  out  1  FSM in S_IDLE and both FIFOs empty
- `sent_cnt`  out  32  bytes handed to `uart_tx` (optional feature)

Behaviour:
- Reset (`rstn`=0 at posedge):
  - FSM goes to S_IDLE; both FIFOs are emptied (pointers and levels 0).
  - Outputs: `tx_start`=0, `tx_sdata`=0, `last_grant`=1 (so port 0 wins the first tie), `p0_ready`=`p1_ready`=1, `sched_idle`=1, `sent_cnt`=0.
  - Reset mid-byte abandons the byte; `uart_tx` is reset by the same `rstn`.
- FIFO push:
  - A push happens when `pN_valid` && `pN_ready` at posedge.
  - `pN_ready` = !full, combinational from level, and does not anticipate a same-cycle pop. A full FIFO refuses a push even while popping.
  - `pN_data` is ignored when not pushed.
- FIFO pointers: DEPTH_LOG2 bits, natural wrap at 2**DEPTH_LOG2. `pN_level` is exact in 0..2**DEPTH_LOG2; a simultaneous push and pop leaves the level unchanged.
- FSM states: S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE.
- S_IDLE:
  - If neither FIFO is non-empty, stay.
  - If exactly one is non-empty, grant it.
  - If both are non-empty, grant the port != `last_grant`.
  - On grant: pop the head into `tx_sdata`, set `last_grant`, go to S_START.
- S_START: `tx_start`=1 for exactly this one cycle, then go to S_WAIT_BUSY.
- S_WAIT_BUSY: stay until `tx_busy`=1, then go to S_WAIT_DONE.
- S_WAIT_DONE: stay until `tx_busy`=0, then go to S_IDLE.
  - The next grant can occur on that S_IDLE cycle, so the byte-to-byte overhead is 3 cycles plus the `uart_tx` frame.
- `tx_start` is registered and decoded from state; it is never high outside S_START.
- `tx_sdata` is stable from S_START through S_WAIT_DONE and changes only on a grant.
- Latency: push into an empty FIFO with the FSM in S_IDLE at posedge k, no competing port:
  - grant/pop at posedge k+1;
  - `tx_start` is high in the cycle following posedge k+1 and samples at posedge k+2.
- Arbitration never preempts: the granted byte is always fully sent before re-arbitration.
- Pushes on either port are accepted in every FSM state.

Optional Feature:
- Macro `UART_TX_SCHED_STAT_EN`.
- Defined: `sent_cnt` increments by 1 on each S_START cycle, 32-bit wrapping (0xFFFFFFFF -> 0), cleared by reset.
- Undefined: `sent_cnt` is tied to constant 0 and no counter register exists. The port list is identical either way.

Test Plan:
- Reset, then idle: hold `rstn`=0 for 2 cycles with `p0_valid`=1 -> `tx_start`=0, `p0_level`=0, `p0_ready`=1, `sched_idle`=1. No push is accepted during reset.
- Single byte: push 0x41 on p0, with a `uart_tx` model raising `tx_busy` 1 cycle after the start and dropping it 1000 cycles later.
  - Required: `tx_start` pulses exactly once, 2 cycles after the push, with `tx_sdata`=0x41 held until `tx_busy` falls.
  - Then `sched_idle`=1.
- Round-robin:
  - Preload p0 with 0x10,0x11,0x12 and p1 with 0x20,0x21 in the same cycles.
  - Required transmit order: 0x10,0x20,0x11,0x21,0x12; `sent_cnt`=5 with the macro defined, 0 without.
- Full boundary (DEPTH_LOG2=4): push 0x00..0x0F on p1 while the FSM is stuck in S_WAIT_DONE (`tx_busy`=1).
  - Required after these pushes: `p1_level`=16, `p1_ready`=0; a 17th byte 0xFF is refused.
  - Releasing `tx_busy` then sends 0x00..0x0F in order, and 0xFF never appears.
- Pointer wrap: stream 40 bytes 0x00..0x27 through p0 with `p0_valid` held high.
  - Required: all 40 bytes are sent in order with none lost or duplicated; `p0_level` never exceeds 16.
- Reset mid-frame: assert `rstn`=0 in S_WAIT_DONE with 3 bytes still queued.
  - Required: afterwards both levels are 0, the FSM is in S_IDLE, and no `tx_start` occurs until a new push.
